// File: rtl/tabla_rom_pkg.sv
// Shared types and constants for the ROM fetch sequencer.
package tabla_rom_pkg;

  // Fetch sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  // Skid buffer depth covers the ROM's single cycle of read latency
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = 2;

endpackage

// File: rtl/rom_skid_fifo.sv
// Two-entry push/pop/flush buffer holding {last, data} words from the ROM.
module rom_skid_fifo
  import tabla_rom_pkg::*;
#(
  parameter int unsigned WIDTH = 17
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [WIDTH-1:0]      o_head,
  output logic                  o_valid,
  output logic [SKID_CNT_W-1:0] o_count
);

  logic [WIDTH-1:0]      r_slot0;
  logic [WIDTH-1:0]      r_slot1;
  logic [SKID_CNT_W-1:0] r_count;
  logic                  r_valid;

  logic [WIDTH-1:0]      w_slot0_nxt;
  logic [WIDTH-1:0]      w_slot1_nxt;
  logic [SKID_CNT_W-1:0] w_count_nxt;
  logic                  w_pop;

  assign w_pop = i_pop & (r_count != '0);

  // Next slot contents and occupancy; slot0 is always the head
  always_comb begin
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    w_count_nxt = r_count;
    if (i_flush) begin
      w_slot0_nxt = '0;
      w_slot1_nxt = '0;
      w_count_nxt = '0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == '0) begin
            w_slot0_nxt = i_push_data;
          end else begin
            w_slot1_nxt = i_push_data;
          end
          if (r_count < SKID_CNT_W'(SKID_DEPTH)) begin
            w_count_nxt = r_count + SKID_CNT_W'(1);
          end
        end
        2'b01: begin
          w_slot0_nxt = r_slot1;
          w_count_nxt = r_count - SKID_CNT_W'(1);
        end
        2'b11: begin
          if (r_count == SKID_CNT_W'(1)) begin
            w_slot0_nxt = i_push_data;
          end else begin
            w_slot0_nxt = r_slot1;
            w_slot1_nxt = i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer storage and registered status
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_slot0 <= w_slot0_nxt;
      r_slot1 <= w_slot1_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign o_head  = r_slot0;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Walks a ROM address window for N passes and streams words over valid/ready.
module rom_fetch_sequencer
  import tabla_rom_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned LOOP_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] START_ADDR,
  input  logic [ADDR_WIDTH-1:0] END_ADDR,
  input  logic [LOOP_WIDTH-1:0] LOOP_COUNT,
  input  logic                  ABORT,
  output logic [ADDR_WIDTH-1:0] ROM_ADDRESS,
  output logic                  ROM_ENABLE,
  input  logic [DATA_WIDTH-1:0] ROM_DATA,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_LAST,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;
  localparam int unsigned CRED_W  = SKID_CNT_W + 1;

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_start_addr;
  logic [ADDR_WIDTH-1:0] r_end_addr;
  logic [LOOP_WIDTH-1:0] r_passes;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_busy;
  logic                  r_done;

  fetch_state_t          w_state_nxt;
  logic                  w_issue;
  logic                  w_accept;
  logic                  w_abort_job;
  logic                  w_end_hit;
  logic                  w_final_issue;
  logic                  w_credit_ok;
  logic                  w_pop;
  logic                  w_push;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_fifo_valid;
  logic [SKID_CNT_W-1:0] w_fifo_count;

  assign w_pop         = w_fifo_valid & OUT_READY;
  assign w_accept      = (r_state == ST_IDLE) & START & ~ABORT;
  assign w_abort_job   = ABORT & ((r_state == ST_RUN) | (r_state == ST_DRAIN));
  assign w_end_hit     = (r_addr == r_end_addr);
  assign w_final_issue = w_issue & w_end_hit & (r_passes == LOOP_WIDTH'(1));
  assign w_push        = r_inflight & ~w_abort_job;

  // Credit: buffered + in-flight words after this cycle's pop must leave room
  assign w_credit_ok = (CRED_W'(w_fifo_count) + CRED_W'(r_inflight))
                     < (CRED_W'(SKID_DEPTH) + CRED_W'(w_pop));

  // Next state and read issue
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_issue = w_credit_ok;
          if (w_credit_ok & w_end_hit & (r_passes == LOOP_WIDTH'(1))) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else if (w_pop & w_head[DATA_WIDTH]) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, window/pass counters and in-flight tracking
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_start_addr    <= '0;
      r_end_addr      <= '0;
      r_passes        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_done          <= (w_state_nxt == ST_DONE);
      r_inflight      <= w_issue;
      r_inflight_last <= w_final_issue;
      if (w_accept) begin
        r_addr       <= START_ADDR;
        r_start_addr <= START_ADDR;
        r_end_addr   <= END_ADDR;
        r_passes     <= (LOOP_COUNT == '0) ? LOOP_WIDTH'(1) : LOOP_COUNT;
      end else if (w_issue) begin
        if (w_end_hit) begin
          r_addr   <= r_start_addr;
          r_passes <= r_passes - LOOP_WIDTH'(1);
        end else begin
          r_addr <= ADDR_WIDTH'(r_addr + ADDR_WIDTH'(1));
        end
      end
    end
  end

  rom_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_skid (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_push      (w_push),
    .i_push_data ({r_inflight_last, ROM_DATA}),
    .i_pop       (w_pop),
    .i_flush     (w_abort_job),
    .o_head      (w_head),
    .o_valid     (w_fifo_valid),
    .o_count     (w_fifo_count)
  );

  assign ROM_ADDRESS = r_addr;
  assign ROM_ENABLE  = w_issue;
  assign OUT_DATA    = w_head[DATA_WIDTH-1:0];
  assign OUT_LAST    = w_head[DATA_WIDTH];
  assign OUT_VALID   = w_fifo_valid;
  assign BUSY        = r_busy;
  assign DONE        = r_done;

endmodule
